// File: rtl/spi_slave_12bit_pkg.sv
// Shared types and helpers for the 12-bit SPI slave: mode decode and FSM state encoding.
package spi_slave_12bit_pkg;

    localparam int unsigned DEFAULT_WORD_W = 12;

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StShift,
        StDone
    } spi_state_e;

    function automatic logic spi_cpol(input int unsigned mode);
        return ((mode >> 1) & 32'd1) != 32'd0;
    endfunction

    function automatic logic spi_cpha(input int unsigned mode);
        return (mode & 32'd1) != 32'd0;
    endfunction

endpackage

// File: rtl/spi_slave_12bit_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronised level versus its one-cycle-delayed copy.
module spi_slave_12bit_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Async,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_dly  <= RESET_VAL;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_Level = r_sync;
    assign o_Rise  = r_sync & ~r_dly;
    assign o_Fall  = ~r_sync & r_dly;

endmodule

// File: rtl/spi_slave_12bit.sv
// SPI slave endpoint: oversamples SCK/CS_n/MOSI in the i_Clk domain, receives one WORD_W-bit
// word per CS_n frame and returns the preloaded reply word on MISO, MSB first.
module spi_slave_12bit
    import spi_slave_12bit_pkg::*;
#(
    parameter int unsigned SPI_MODE  = 0,
    parameter int unsigned WORD_W    = DEFAULT_WORD_W,
    parameter logic        MISO_IDLE = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [WORD_W-1:0] i_TX_Word,
    input  logic              i_TX_DV,
    output logic              o_RX_DV,
    output logic [WORD_W-1:0] o_RX_Word,
    output logic              o_RX_Err,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_En
);

    localparam logic              CPOL     = spi_cpol(SPI_MODE);
    localparam logic              CPHA     = spi_cpha(SPI_MODE);
    localparam int unsigned       CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);

    logic w_sck_level_unused;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_slave_12bit_sync_edge #(
        .RESET_VAL (CPOL)
    ) u_sync_sck (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Async (i_SPI_Clk),
        .o_Level (w_sck_level_unused),
        .o_Rise  (w_sck_rise),
        .o_Fall  (w_sck_fall)
    );

    // Resets to "selected" so a frame already in progress at reset release is never joined.
    spi_slave_12bit_sync_edge #(
        .RESET_VAL (1'b0)
    ) u_sync_cs (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Async (i_SPI_CS_n),
        .o_Level (w_cs_level),
        .o_Rise  (w_cs_rise),
        .o_Fall  (w_cs_fall)
    );

    spi_slave_12bit_sync_edge #(
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Async (i_SPI_MOSI),
        .o_Level (w_mosi),
        .o_Rise  (w_mosi_rise_unused),
        .o_Fall  (w_mosi_fall_unused)
    );

    logic w_lead_edge;
    logic w_trail_edge;
    logic w_sample_edge;
    logic w_shift_edge;

    assign w_lead_edge   = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail_edge  = CPOL ? w_sck_rise : w_sck_fall;
    assign w_sample_edge = CPHA ? w_trail_edge : w_lead_edge;
    assign w_shift_edge  = CPHA ? w_lead_edge : w_trail_edge;

    spi_state_e        r_state;
    spi_state_e        w_state_d;
    logic [WORD_W-1:0] r_buf;
    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_rx;
    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;
    logic              r_miso;
    logic              r_miso_en;
    logic              r_rx_dv;
    logic              r_rx_err;

    logic w_load;
    logic w_sample;
    logic w_shift;
    logic w_finish;
    logic w_abort;
    logic w_close;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= StWaitIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_sample  = 1'b0;
        w_shift   = 1'b0;
        w_finish  = 1'b0;
        w_abort   = 1'b0;
        w_close   = 1'b0;
        unique case (r_state)
            StWaitIdle: begin
                if (w_cs_level) begin
                    w_state_d = StIdle;
                end
            end
            StIdle: begin
                if (w_cs_fall) begin
                    w_load    = 1'b1;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (r_count == CNT_FULL) begin
                    w_finish  = 1'b1;
                    w_close   = w_cs_rise;
                    w_state_d = w_cs_rise ? StIdle : StDone;
                end else if (w_cs_rise) begin
                    w_close   = 1'b1;
                    w_abort   = (r_count != '0);
                    w_state_d = StIdle;
                end else begin
                    w_sample = w_sample_edge;
                    w_shift  = w_shift_edge;
                end
            end
            StDone: begin
                if (w_cs_rise) begin
                    w_close   = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StWaitIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_buf     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_word    <= '0;
            r_count   <= '0;
            r_miso    <= MISO_IDLE;
            r_miso_en <= 1'b0;
            r_rx_dv   <= 1'b0;
            r_rx_err  <= 1'b0;
        end else begin
            r_rx_dv  <= 1'b0;
            r_rx_err <= 1'b0;
            if (i_TX_DV) begin
                r_buf <= i_TX_Word;
            end
            // The buffer is read before this cycle's i_TX_DV lands, so a coincident
            // strobe only affects the next frame.
            if (w_load) begin
                r_count   <= '0;
                r_rx      <= '0;
                r_miso_en <= 1'b1;
                if (!CPHA) begin
                    r_miso <= r_buf[WORD_W-1];
                    r_tx   <= {r_buf[WORD_W-2:0], 1'b0};
                end else begin
                    r_miso <= MISO_IDLE;
                    r_tx   <= r_buf;
                end
            end
            if (w_sample) begin
                r_rx    <= {r_rx[WORD_W-2:0], w_mosi};
                r_count <= r_count + CNT_W'(1);
            end
            if (w_shift) begin
                r_miso <= r_tx[WORD_W-1];
                r_tx   <= {r_tx[WORD_W-2:0], 1'b0};
            end
            if (w_finish) begin
                r_word  <= r_rx;
                r_rx_dv <= 1'b1;
                r_miso  <= MISO_IDLE;
            end
            if (w_close) begin
                r_miso_en <= 1'b0;
                r_miso    <= MISO_IDLE;
            end
            if (w_abort) begin
                r_rx_err <= 1'b1;
            end
        end
    end

    assign o_RX_DV       = r_rx_dv;
    assign o_RX_Word     = r_word;
    assign o_RX_Err      = r_rx_err;
    assign o_SPI_MISO    = r_miso;
    assign o_SPI_MISO_En = r_miso_en;

endmodule

// File: tb/tb_spi_slave_12bit.sv
// Self-checking bench: one slave per SPI mode, driven by a behavioural master (4 clocks per
// half bit); expected words come from a per-mode model of the reply buffer and last RX word.
module tb_spi_slave_12bit;

    localparam int HALF = 4;

    logic        clk;
    logic        rst;
    logic [11:0] tx_word [4];
    logic        tx_dv   [4];
    logic        rx_dv   [4];
    logic [11:0] rx_word [4];
    logic        rx_err  [4];
    logic        sck     [4];
    logic        cs_n    [4];
    logic        mosi    [4];
    logic        miso    [4];
    logic        miso_en [4];

    int dv_cnt  [4] = '{default: 0};
    int err_cnt [4] = '{default: 0};

    logic [11:0] model_buf  [4];
    logic [11:0] model_word [4];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_12bit #(
            .SPI_MODE  (g),
            .WORD_W    (12),
            .MISO_IDLE (1'b0)
        ) u_dut (
            .i_Clk         (clk),
            .i_Rst         (rst),
            .i_TX_Word     (tx_word[g]),
            .i_TX_DV       (tx_dv[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Word     (rx_word[g]),
            .o_RX_Err      (rx_err[g]),
            .i_SPI_Clk     (sck[g]),
            .i_SPI_CS_n    (cs_n[g]),
            .i_SPI_MOSI    (mosi[g]),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_En (miso_en[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) dv_cnt[m] <= dv_cnt[m] + 1;
            if (rx_err[m] === 1'b1) err_cnt[m] <= err_cnt[m] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_tx(input int m, input logic [11:0] w);
        @(negedge clk);
        tx_word[m] = w;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
        model_buf[m] = w;
    endtask

    // Behavioural SPI master: nbits SCK cycles, optionally releases CS_n afterwards.
    task automatic xfer(input int m, input logic [11:0] tx, input int nbits, input bit raise,
                        output logic [11:0] rx);
        logic cpol;
        logic cpha;
        cpol = ((m >> 1) & 1) != 0;
        cpha = (m & 1) != 0;
        rx   = '0;
        @(negedge clk);
        cs_n[m] = 1'b0;
        if (!cpha) mosi[m] = tx[11];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sck[m] = ~cpol;
            if (cpha) mosi[m] = tx[11-i];
            else rx = {rx[10:0], miso[m]};
            repeat (HALF) @(negedge clk);
            sck[m] = cpol;
            if (cpha) rx = {rx[10:0], miso[m]};
            else if (i < 11) mosi[m] = tx[10-i];
            repeat (HALF) @(negedge clk);
        end
        if (raise) cs_n[m] = 1'b1;
    endtask

    task automatic full_frame(input int m, input logic [11:0] w, input int gap, input string tag);
        int          dv0;
        int          err0;
        logic [11:0] got;
        logic [11:0] reply;
        dv0   = dv_cnt[m];
        err0  = err_cnt[m];
        reply = model_buf[m];
        xfer(m, w, 12, 1'b1, got);
        model_word[m] = w;
        repeat (gap) @(negedge clk);
        chk($sformatf("%s m%0d dv", tag, m), dv_cnt[m] - dv0, 1);
        chk($sformatf("%s m%0d err", tag, m), err_cnt[m] - err0, 0);
        chk($sformatf("%s m%0d rx_word", tag, m), rx_word[m], model_word[m]);
        chk($sformatf("%s m%0d reply", tag, m), got, reply);
    endtask

    initial begin
        logic [11:0] got;
        int          dv0;
        int          err0;

        rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            tx_word[m]    = '0;
            tx_dv[m]      = 1'b0;
            sck[m]        = ((m >> 1) & 1) != 0;
            cs_n[m]       = 1'b1;
            mosi[m]       = 1'b0;
            model_buf[m]  = '0;
            model_word[m] = '0;
        end

        repeat (10) begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) chk($sformatf("rst m%0d miso_en", m), miso_en[m], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst m%0d dv", m), rx_dv[m], 0);
            chk($sformatf("rst m%0d err", m), rx_err[m], 0);
            chk($sformatf("rst m%0d word", m), rx_word[m], 0);
            chk($sformatf("rst m%0d miso", m), miso[m], 0);
        end
        repeat (4) @(negedge clk);

        // Directed exchanges in every mode.
        load_tx(0, 12'h3F1);
        full_frame(0, 12'hA5C, 4, "mode0");
        for (int m = 1; m < 4; m++) begin
            load_tx(m, 12'h801);
            full_frame(m, 12'h7FE, 4, "modeN");
        end

        // Aborted frame after 5 SCK cycles, then a normal frame.
        dv0  = dv_cnt[0];
        err0 = err_cnt[0];
        xfer(0, 12'h5A5, 5, 1'b1, got);
        repeat (6) @(negedge clk);
        chk("abort err", err_cnt[0] - err0, 1);
        chk("abort dv", dv_cnt[0] - dv0, 0);
        chk("abort word held", rx_word[0], model_word[0]);
        chk("abort miso_en", miso_en[0], 0);
        full_frame(0, 12'h123, 4, "post_abort");

        // Back-to-back frames with a 3-cycle gap and no buffer rewrite.
        full_frame(0, 12'hFFF, 3, "b2b0");
        full_frame(0, 12'h000, 4, "b2b1");

        // Reset at bit 6 with CS_n still low; remainder of the frame must be ignored.
        dv0  = dv_cnt[0];
        err0 = err_cnt[0];
        xfer(0, 12'hC3C, 6, 1'b0, got);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int m = 0; m < 4; m++) begin
            model_buf[m]  = '0;
            model_word[m] = '0;
        end
        for (int i = 0; i < 6; i++) begin
            sck[0] = 1'b1;
            mosi[0] = 1'($urandom_range(1));
            repeat (HALF) @(negedge clk);
            chk("midrst miso_en low", miso_en[0], 0);
            sck[0] = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        cs_n[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst dv", dv_cnt[0] - dv0, 0);
        chk("midrst err", err_cnt[0] - err0, 0);
        chk("midrst word", rx_word[0], 0);
        full_frame(0, 12'h9B6, 4, "post_rst");

        // Randomised frames in every mode; buffer rewritten on about half of them.
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(1) == 1) load_tx(m, 12'($urandom));
                full_frame(m, 12'($urandom), 3 + $urandom_range(3), "rand");
                chk($sformatf("rand m%0d miso idle", m), miso[m], 0);
                chk($sformatf("rand m%0d miso_en", m), miso_en[m], 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
